// File: rtl/rk4_stage_scheduler.sv
// RK4 step sequencer: fixed-rate tick, input freeze, four-stage k1..k4 evaluation, state commit.
// Optional derivative-unit watchdog enabled by defining RK4_SCHED_TIMEOUT_EN.
module rk4_stage_scheduler #(
  parameter int TICK_DIV     = 100,
  parameter int DONE_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr_err,
  input  logic [31:0] voltage_in,
  input  logic [31:0] load_in,
  output logic [31:0] voltage_q,
  output logic [31:0] load_q,
  output logic        eval_start,
  output logic [1:0]  eval_stage,
  output logic        eval_half,
  input  logic        eval_done,
  output logic        acc_we,
  output logic [1:0]  acc_weight,
  output logic        state_we,
  output logic        step_done,
  output logic [31:0] step_count,
  output logic        busy,
  output logic        overrun,
  output logic        err_timeout
);

  // Tick and WAIT counters share one width, sized for the larger limit.
  localparam int CNT_MAX = (TICK_DIV > DONE_TIMEOUT) ? TICK_DIV : DONE_TIMEOUT;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] TCNT_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_COMMIT,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  tcnt_q, tcnt_d;
  logic [1:0]        stage_q, stage_d;
  logic [31:0]       voltage_d, load_d;
  logic [31:0]       step_count_q, step_count_d;
  logic              eval_start_q, eval_start_d;
  logic              state_we_q, state_we_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              tick;
  logic              timeout_hit;

`ifdef RK4_SCHED_TIMEOUT_EN
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(DONE_TIMEOUT - 1);
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic              err_timeout_q, err_timeout_d;
`endif

  assign tick = en && (tcnt_q == TCNT_LAST);

  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    voltage_d    = voltage_q;
    load_d       = load_q;
    step_count_d = step_count_q;
    eval_start_d = 1'b0;
    state_we_d   = 1'b0;
    timeout_hit  = 1'b0;
    tcnt_d       = en ? (tick ? '0 : tcnt_q + CNT_W'(1)) : '0;
`ifdef RK4_SCHED_TIMEOUT_EN
    wcnt_d       = wcnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          voltage_d    = voltage_in;
          load_d       = load_in;
          stage_d      = 2'd0;
          eval_start_d = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef RK4_SCHED_TIMEOUT_EN
        wcnt_d  = '0;
`endif
      end
      S_WAIT: begin
        if (eval_done) begin
          if (stage_q == 2'd3) begin
            state_we_d   = 1'b1;
            step_count_d = step_count_q + 32'd1;
            state_d      = S_COMMIT;
          end else begin
            stage_d      = stage_q + 2'd1;
            eval_start_d = 1'b1;
            state_d      = S_ISSUE;
          end
        end
`ifdef RK4_SCHED_TIMEOUT_EN
        else if (wcnt_q == WAIT_LAST) begin
          timeout_hit = 1'b1;
          state_d     = S_ERR;
        end else begin
          wcnt_d = wcnt_q + CNT_W'(1);
        end
`endif
      end
      S_COMMIT: state_d = S_IDLE;
      S_ERR: begin
        if (clr_err) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);

    // A new set event beats a simultaneous clear.
    if (tick && (state_q != S_IDLE)) overrun_d = 1'b1;
    else if (clr_err)                overrun_d = 1'b0;
    else                             overrun_d = overrun_q;

`ifdef RK4_SCHED_TIMEOUT_EN
    if (timeout_hit)  err_timeout_d = 1'b1;
    else if (clr_err) err_timeout_d = 1'b0;
    else              err_timeout_d = err_timeout_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      tcnt_q        <= '0;
      stage_q       <= 2'd0;
      voltage_q     <= 32'd0;
      load_q        <= 32'd0;
      step_count_q  <= 32'd0;
      eval_start_q  <= 1'b0;
      state_we_q    <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef RK4_SCHED_TIMEOUT_EN
      wcnt_q        <= '0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      tcnt_q        <= tcnt_d;
      stage_q       <= stage_d;
      voltage_q     <= voltage_d;
      load_q        <= load_d;
      step_count_q  <= step_count_d;
      eval_start_q  <= eval_start_d;
      state_we_q    <= state_we_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
`ifdef RK4_SCHED_TIMEOUT_EN
      wcnt_q        <= wcnt_d;
      err_timeout_q <= err_timeout_d;
`endif
    end
  end

  assign eval_start = eval_start_q;
  assign eval_stage = stage_q;
  assign eval_half  = (stage_q == 2'd1) || (stage_q == 2'd2);
  assign acc_weight = eval_half ? 2'd2 : 2'd1;
  assign acc_we     = (state_q == S_WAIT) && eval_done;
  assign state_we   = state_we_q;
  assign step_done  = state_we_q;
  assign step_count = step_count_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
`ifdef RK4_SCHED_TIMEOUT_EN
  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule
